// File: rtl/video_timing_gen_if.sv
// Pixel-pair stream from the upstream pixel source into video_timing_gen.
// Each 16-bit channel carries two pixels: [7:0] left pixel, [15:8] right pixel.
interface video_timing_gen_if;
  logic        pix_valid;
  logic        pix_ready;
  logic [15:0] pix_data_r;
  logic [15:0] pix_data_g;
  logic [15:0] pix_data_b;

  modport master (
    output pix_valid,
    output pix_data_r,
    output pix_data_g,
    output pix_data_b,
    input  pix_ready
  );

  modport slave (
    input  pix_valid,
    input  pix_data_r,
    input  pix_data_g,
    input  pix_data_b,
    output pix_ready
  );
endinterface

// File: rtl/video_timing_gen.sv
// Video timing generator: produces hsync/vsync/de for an LVDS packer and
// passes pixel pairs through with one clock of latency (2 pixels per clock).
// When the upstream source is starved on an active clock, timing keeps going,
// a fill value is sent and an underflow is flagged.
// Optional feature macro: VIDEO_TIMING_GEN_TESTPAT_EN selects 8 vertical
// colour bars as the underflow fill instead of black.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | counters held at 0, no output activity
// RUN   | counters advance every clock, frames repeat while enable=1
// DRAIN | enable dropped: finish the current frame, then return to IDLE
module video_timing_gen #(
  parameter int H_ACTIVE = 320,
  parameter int H_FP     = 8,
  parameter int H_SYNC   = 48,
  parameter int H_BP     = 24,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     enable,
  video_timing_gen_if.slave        pix,
  output logic                     out_vsync,
  output logic                     out_hsync,
  output logic                     out_de,
  output logic [15:0]              out_data_r,
  output logic [15:0]              out_data_g,
  output logic [15:0]              out_data_b,
  output logic                     frame_start,
  output logic                     underflow,
  output logic                     underflow_sticky,
  input  logic                     underflow_clr
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // One extra value of headroom so the sync-end bound never truncates.
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [HW-1:0]   h_cnt;
  logic [VW-1:0]   v_cnt;
  logic            h_end;
  logic            v_end;
  logic            active;
  logic            hs_region;
  logic            vs_region;
  logic            starved;
  logic [15:0]     fill_r;
  logic [15:0]     fill_g;
  logic [15:0]     fill_b;

  assign h_end     = (h_cnt == H_LAST);
  assign v_end     = (v_cnt == V_LAST);
  assign active    = (state != IDLE) && (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_region = (h_cnt >= H_SS) && (h_cnt < H_SE);
  assign vs_region = (v_cnt >= V_SS) && (v_cnt < V_SE);
  assign starved   = active & ~pix.pix_valid;

  // A pair is taken on every active clock; starvation never stalls timing.
  assign pix.pix_ready = active;

`ifdef VIDEO_TIMING_GEN_TESTPAT_EN
  logic [2:0] bar;
  logic [2:0] bar_rgb;

  assign bar = 3'((32'(h_cnt) * 32'd8) / 32'(H_ACTIVE));

  // Bar colour as {r,g,b} on/off: white, yellow, cyan, green, magenta, red, blue, black.
  always_comb begin
    bar_rgb = 3'b000;
    case (bar)
      3'd0:    bar_rgb = 3'b111;
      3'd1:    bar_rgb = 3'b110;
      3'd2:    bar_rgb = 3'b011;
      3'd3:    bar_rgb = 3'b010;
      3'd4:    bar_rgb = 3'b101;
      3'd5:    bar_rgb = 3'b100;
      3'd6:    bar_rgb = 3'b001;
      default: bar_rgb = 3'b000;
    endcase
  end

  assign fill_r = {16{bar_rgb[2]}};
  assign fill_g = {16{bar_rgb[1]}};
  assign fill_b = {16{bar_rgb[0]}};
`else
  assign fill_r = '0;
  assign fill_g = '0;
  assign fill_b = '0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state; DRAIN only returns to IDLE on the last clock of a frame.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (!enable) state_nxt = DRAIN;
      DRAIN: begin
        if (enable)              state_nxt = RUN;
        else if (h_end && v_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Raster counters: held at 0 in IDLE, free-running otherwise.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (state == IDLE) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_end) begin
      h_cnt <= '0;
      v_cnt <= v_end ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  // Registered outputs, one clock behind the counter state that produced them.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_de           <= 1'b0;
      out_hsync        <= ~SYNC_POL;
      out_vsync        <= ~SYNC_POL;
      out_data_r       <= '0;
      out_data_g       <= '0;
      out_data_b       <= '0;
      frame_start      <= 1'b0;
      underflow        <= 1'b0;
      underflow_sticky <= 1'b0;
    end else begin
      out_de      <= active;
      out_hsync   <= hs_region ? SYNC_POL : ~SYNC_POL;
      out_vsync   <= vs_region ? SYNC_POL : ~SYNC_POL;
      frame_start <= (state != IDLE) && (h_cnt == '0) && (v_cnt == '0);
      underflow   <= starved;
      if (!active) begin
        out_data_r <= '0;
        out_data_g <= '0;
        out_data_b <= '0;
      end else if (pix.pix_valid) begin
        out_data_r <= pix.pix_data_r;
        out_data_g <= pix.pix_data_g;
        out_data_b <= pix.pix_data_b;
      end else begin
        out_data_r <= fill_r;
        out_data_g <= fill_g;
        out_data_b <= fill_b;
      end
      // A new underflow beats a simultaneous clear so no event is lost.
      if (starved)            underflow_sticky <= 1'b1;
      else if (underflow_clr) underflow_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed testbench for video_timing_gen with a small 8x6 raster
// (4 active clocks + 1/2/1 porch/sync/porch, 3 active lines + 1/1/1).
module tb_video_timing_gen;

  localparam int HT = 8;
  localparam int FT = 48;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic        underflow_clr;
  logic        out_vsync;
  logic        out_hsync;
  logic        out_de;
  logic [15:0] out_data_r;
  logic [15:0] out_data_g;
  logic [15:0] out_data_b;
  logic        frame_start;
  logic        underflow;
  logic        underflow_sticky;

  int total = 0;
  int bad   = 0;

  video_timing_gen_if pif();

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b1)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .enable           (enable),
    .pix              (pif),
    .out_vsync        (out_vsync),
    .out_hsync        (out_hsync),
    .out_de           (out_de),
    .out_data_r       (out_data_r),
    .out_data_g       (out_data_g),
    .out_data_b       (out_data_b),
    .frame_start      (frame_start),
    .underflow        (underflow),
    .underflow_sticky (underflow_sticky),
    .underflow_clr    (underflow_clr)
  );

  always #5 clk = ~clk;

`ifdef VIDEO_TIMING_GEN_TESTPAT_EN
  // h_cnt=2 -> bar 4 -> magenta
  localparam logic [15:0] FILL_R = 16'hFFFF;
  localparam logic [15:0] FILL_G = 16'h0000;
  localparam logic [15:0] FILL_B = 16'hFFFF;
`else
  localparam logic [15:0] FILL_R = 16'h0000;
  localparam logic [15:0] FILL_G = 16'h0000;
  localparam logic [15:0] FILL_B = 16'h0000;
`endif

  // Geometry of frame position p (0..47) for the 8x6 raster.
  function automatic logic exp_act(int p);
    return ((p % HT) < 4) && ((p / HT) < 3);
  endfunction
  function automatic logic exp_hs(int p);
    return ((p % HT) >= 5) && ((p % HT) < 7);
  endfunction
  function automatic logic exp_vs(int p);
    return (p / HT) == 4;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(int n);
    logic [15:0] v;
    v = {8'(2 * n + 1), 8'(2 * n)};
    pif.pix_data_r = v;
    pif.pix_data_g = v ^ 16'hFFFF;
    pif.pix_data_b = v + 16'h4040;
  endtask

  // Reset, then enable; returns with the counters at position 0 in RUN.
  task automatic start_frame();
    resetn        = 1'b0;
    enable        = 1'b0;
    underflow_clr = 1'b0;
    pif.pix_valid = 1'b1;
    #3;
    resetn = 1'b1;
    enable = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    resetn         = 1'b0;
    enable         = 1'b0;
    underflow_clr  = 1'b0;
    pif.pix_valid  = 1'b0;
    pif.pix_data_r = '0;
    pif.pix_data_g = '0;
    pif.pix_data_b = '0;
    #2;
    total++; if (out_de !== 1'b0) begin bad++; $display("FAIL reset_de got=%b exp=0", out_de); end
    total++; if (out_hsync !== 1'b0) begin bad++; $display("FAIL reset_hsync got=%b exp=0", out_hsync); end
    total++; if (out_vsync !== 1'b0) begin bad++; $display("FAIL reset_vsync got=%b exp=0", out_vsync); end
    total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL reset_fs got=%b exp=0", frame_start); end
    total++; if (underflow_sticky !== 1'b0) begin bad++; $display("FAIL reset_sticky got=%b exp=0", underflow_sticky); end
    total++; if (pif.pix_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", pif.pix_ready); end
    total++; if (out_data_r !== 16'h0) begin bad++; $display("FAIL reset_data got=%h exp=0000", out_data_r); end
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (pif.pix_ready !== 1'b0) begin bad++; $display("FAIL idle_ready i=%0d got=%b exp=0", i, pif.pix_ready); end
      total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL idle_fs i=%0d got=%b exp=0", i, frame_start); end
    end
  endtask

  task automatic test_timing();
    start_frame();
    pif.pix_data_r = 16'h1234;
    pif.pix_data_g = 16'h5678;
    pif.pix_data_b = 16'h9ABC;
    for (int i = 0; i < 2 * FT; i++) begin
      int p;
      p = i % FT;
      total++; if (pif.pix_ready !== exp_act(p)) begin bad++; $display("FAIL tim_ready i=%0d got=%b exp=%b", i, pif.pix_ready, exp_act(p)); end
      tick();
      total++; if (out_de !== exp_act(p)) begin bad++; $display("FAIL tim_de i=%0d got=%b exp=%b", i, out_de, exp_act(p)); end
      total++; if (out_hsync !== exp_hs(p)) begin bad++; $display("FAIL tim_hsync i=%0d got=%b exp=%b", i, out_hsync, exp_hs(p)); end
      total++; if (out_vsync !== exp_vs(p)) begin bad++; $display("FAIL tim_vsync i=%0d got=%b exp=%b", i, out_vsync, exp_vs(p)); end
      total++; if (frame_start !== (p == 0)) begin bad++; $display("FAIL tim_fs i=%0d got=%b exp=%b", i, frame_start, (p == 0)); end
      total++; if (underflow !== 1'b0) begin bad++; $display("FAIL tim_uf i=%0d got=%b exp=0", i, underflow); end
      total++; if (out_data_r !== (exp_act(p) ? 16'h1234 : 16'h0000)) begin bad++; $display("FAIL tim_data_r i=%0d got=%h", i, out_data_r); end
      total++; if (out_data_b !== (exp_act(p) ? 16'h9ABC : 16'h0000)) begin bad++; $display("FAIL tim_data_b i=%0d got=%h", i, out_data_b); end
    end
  endtask

  task automatic test_data();
    int n;
    logic cons;
    logic [15:0] er, eg, eb;
    start_frame();
    n = 0;
    set_pix(0);
    for (int i = 0; i < 60; i++) begin
      cons = pif.pix_ready & pif.pix_valid;
      er = pif.pix_data_r;
      eg = pif.pix_data_g;
      eb = pif.pix_data_b;
      tick();
      if (cons) begin
        total++; if (out_de !== 1'b1) begin bad++; $display("FAIL data_de i=%0d got=%b exp=1", i, out_de); end
        total++; if ({out_data_r, out_data_g, out_data_b} !== {er, eg, eb})
          begin bad++; $display("FAIL data_val i=%0d got=%h/%h/%h exp=%h/%h/%h", i, out_data_r, out_data_g, out_data_b, er, eg, eb); end
        n++;
        set_pix(n);
      end else begin
        total++; if (out_de !== 1'b0) begin bad++; $display("FAIL data_gap i=%0d got=%b exp=0", i, out_de); end
      end
    end
    total++; if (n !== 20) begin bad++; $display("FAIL data_count got=%0d exp=20", n); end
  endtask

  task automatic test_underflow();
    start_frame();
    pif.pix_data_r = 16'h1234;
    pif.pix_data_g = 16'h5678;
    pif.pix_data_b = 16'h9ABC;
    repeat (10) tick();
    pif.pix_valid = 1'b0;
    total++; if (pif.pix_ready !== 1'b1) begin bad++; $display("FAIL uf_ready got=%b exp=1", pif.pix_ready); end
    tick();
    pif.pix_valid = 1'b1;
    total++; if (out_de !== 1'b1) begin bad++; $display("FAIL uf_de got=%b exp=1", out_de); end
    total++; if (underflow !== 1'b1) begin bad++; $display("FAIL uf_pulse got=%b exp=1", underflow); end
    total++; if (underflow_sticky !== 1'b1) begin bad++; $display("FAIL uf_sticky got=%b exp=1", underflow_sticky); end
    total++; if ({out_data_r, out_data_g, out_data_b} !== {FILL_R, FILL_G, FILL_B})
      begin bad++; $display("FAIL uf_fill got=%h/%h/%h exp=%h/%h/%h", out_data_r, out_data_g, out_data_b, FILL_R, FILL_G, FILL_B); end
    tick();
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL uf_pulse_end got=%b exp=0", underflow); end
    total++; if (underflow_sticky !== 1'b1) begin bad++; $display("FAIL uf_sticky_hold got=%b exp=1", underflow_sticky); end
    total++; if (out_data_r !== 16'h1234) begin bad++; $display("FAIL uf_resume got=%h exp=1234", out_data_r); end
  endtask

  task automatic test_clear_race();
    start_frame();
    tick();
    pif.pix_valid = 1'b0;
    underflow_clr = 1'b1;
    tick();
    pif.pix_valid = 1'b1;
    total++; if (underflow !== 1'b1) begin bad++; $display("FAIL race_pulse got=%b exp=1", underflow); end
    total++; if (underflow_sticky !== 1'b1) begin bad++; $display("FAIL race_sticky got=%b exp=1", underflow_sticky); end
    tick();
    underflow_clr = 1'b0;
    total++; if (underflow_sticky !== 1'b0) begin bad++; $display("FAIL race_clear got=%b exp=0", underflow_sticky); end
    tick();
    total++; if (underflow_sticky !== 1'b0) begin bad++; $display("FAIL race_stay got=%b exp=0", underflow_sticky); end
  endtask

  task automatic test_drain();
    start_frame();
    repeat (11) tick();
    enable = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      int p;
      p = 11 + k;
      tick();
      if (p < FT) begin
        total++; if (pif.pix_ready !== exp_act(p)) begin bad++; $display("FAIL drain_ready k=%0d got=%b exp=%b", k, pif.pix_ready, exp_act(p)); end
        total++; if (out_hsync !== exp_hs(p - 1)) begin bad++; $display("FAIL drain_hsync k=%0d got=%b exp=%b", k, out_hsync, exp_hs(p - 1)); end
      end else begin
        total++; if (pif.pix_ready !== 1'b0) begin bad++; $display("FAIL drain_idle_ready k=%0d got=%b exp=0", k, pif.pix_ready); end
        total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL drain_idle_fs k=%0d got=%b exp=0", k, frame_start); end
        total++; if (out_de !== 1'b0) begin bad++; $display("FAIL drain_idle_de k=%0d got=%b exp=0", k, out_de); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int found;
    start_frame();
    tick();
    total++; if (frame_start !== 1'b1) begin bad++; $display("FAIL b2b_first got=%b exp=1", frame_start); end
    found = 0;
    for (int t = 2; t <= 120; t++) begin
      if (t - 1 == 11) enable = 1'b0;
      if (t - 1 == 20) enable = 1'b1;
      tick();
      if (frame_start === 1'b1) begin
        found = t;
        break;
      end
    end
    total++; if (found !== 49) begin bad++; $display("FAIL b2b_period got=%0d exp=49 (0 = timeout)", found); end
  endtask

  task automatic test_reset_mid();
    start_frame();
    repeat (9) tick();
    pif.pix_valid = 1'b0;
    tick();
    pif.pix_valid = 1'b1;
    total++; if (underflow_sticky !== 1'b1) begin bad++; $display("FAIL rst_pre_sticky got=%b exp=1", underflow_sticky); end
    #2;
    resetn = 1'b0;
    #1;
    total++; if (out_de !== 1'b0) begin bad++; $display("FAIL rst_de got=%b exp=0", out_de); end
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL rst_uf got=%b exp=0", underflow); end
    total++; if (underflow_sticky !== 1'b0) begin bad++; $display("FAIL rst_sticky got=%b exp=0", underflow_sticky); end
    total++; if (pif.pix_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", pif.pix_ready); end
    total++; if ({out_data_r, out_data_g, out_data_b} !== 48'h0) begin bad++; $display("FAIL rst_data got=%h/%h/%h exp=0", out_data_r, out_data_g, out_data_b); end
    total++; if ({out_hsync, out_vsync, frame_start} !== 3'b000) begin bad++; $display("FAIL rst_sync got=%b exp=000", {out_hsync, out_vsync, frame_start}); end
    #2;
    resetn = 1'b1;
    tick();
    total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL rst_fs1 got=%b exp=0", frame_start); end
    total++; if (pif.pix_ready !== 1'b1) begin bad++; $display("FAIL rst_run_ready got=%b exp=1", pif.pix_ready); end
    tick();
    total++; if (frame_start !== 1'b1) begin bad++; $display("FAIL rst_fs2 got=%b exp=1", frame_start); end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_data();
    test_underflow();
    test_clear_race();
    test_drain();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
